// File: rtl/mips_ctrl_pkg.sv
// Shared encodings, the pipelined control bundle and the D-stage decoder
// for the MIPS control unit with hi/lo multiply/divide support.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;

   localparam logic [5:0] ALU_ADD  = 6'b100000;
   localparam logic [5:0] ALU_SUB  = 6'b100010;
   localparam logic [5:0] ALU_NOOP = 6'b111111;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   typedef enum logic [1:0] {
      SEL_ALU = 2'd0,
      SEL_MEM = 2'd1,
      SEL_HI  = 2'd2,
      SEL_LO  = 2'd3
   } data_sel_e;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } muldiv_op_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      data_sel_e  data_sel;
      logic [5:0] alu_control;
      logic       alu_src_b_sel;
      logic       write_addr3_sel;
      logic       muldiv_start;
      logic [1:0] muldiv_op;
   } ctrl_bundle_t;

   typedef struct packed {
      logic      reg_write;
      logic      mem_write;
      data_sel_e data_sel;
   } mem_ctrl_t;

   typedef struct packed {
      logic      reg_write;
      data_sel_e data_sel;
   } wb_ctrl_t;

   localparam ctrl_bundle_t BUBBLE = '{
      reg_write:       1'b0,
      mem_write:       1'b0,
      data_sel:        SEL_ALU,
      alu_control:     ALU_NOOP,
      alu_src_b_sel:   1'b0,
      write_addr3_sel: 1'b0,
      muldiv_start:    1'b0,
      muldiv_op:       2'd0
   };

   // Instructions that read or write HI/LO and so must wait for the muldiv unit.
   function automatic logic uses_hi_lo(input logic [5:0] opcode, input logic [5:0] funct);
      return (opcode == OP_RTYPE) &&
             (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO});
   endfunction

   function automatic ctrl_bundle_t decode(input logic [5:0] opcode, input logic [5:0] funct);
      ctrl_bundle_t c;
      c = BUBBLE;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               F_SLL, F_SRL, F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT: begin
                  c.reg_write   = 1'b1;
                  c.alu_control = funct;
               end
               F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                  c.muldiv_start = 1'b1;
                  c.muldiv_op    = funct[1:0];
               end
               F_MFHI: begin
                  c.reg_write = 1'b1;
                  c.data_sel  = SEL_HI;
               end
               F_MFLO: begin
                  c.reg_write = 1'b1;
                  c.data_sel  = SEL_LO;
               end
               default: ;
            endcase
         end
         OP_ADDI, OP_LW: begin
            c.reg_write       = 1'b1;
            c.alu_control     = ALU_ADD;
            c.alu_src_b_sel   = 1'b1;
            c.write_addr3_sel = 1'b1;
            if (opcode == OP_LW) c.data_sel = SEL_MEM;
         end
         OP_SW: begin
            c.mem_write       = 1'b1;
            c.alu_control     = ALU_ADD;
            c.alu_src_b_sel   = 1'b1;
            c.write_addr3_sel = 1'b1;
         end
         OP_BEQ, OP_BNE: c.alu_control = ALU_SUB;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/muldiv_busy_tracker.sv
// Down-counter tracking how long the multi-cycle multiply/divide unit stays
// busy; pulses the HI/LO commit on the last busy cycle.
module muldiv_busy_tracker
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 4,
   parameter int unsigned DIV_LATENCY = 32
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic [1:0] op,
   output logic       hi_lo_busy,
   output logic       hi_lo_write_enable
);

   localparam int unsigned MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
   localparam int unsigned CW      = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LATENCY);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LATENCY);

   logic [CW-1:0] count;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (start) begin
         count <= (op == MD_DIV || op == MD_DIVU) ? DIV_LOAD : MUL_LOAD;
      end else if (count != '0) begin
         count <= count - CW'(1);
      end
   end

   assign hi_lo_busy         = (count != '0);
   assign hi_lo_write_enable = (count == CW'(1));

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined MIPS control unit: D-stage decode, registered E/M/W control
// bundles with bubble insertion, and the muldiv decode stall.
module pipe_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 4,
   parameter int unsigned DIV_LATENCY = 32
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [5:0] opcode_d,
   input  logic [5:0] funct_d,
   input  logic       equal_d,
   input  logic       flush_e,
   output logic [1:0] pc_sel_d,
   output logic       stall_fd,
   output logic [5:0] alu_control_e,
   output logic       alu_src_b_sel_e,
   output logic       write_addr3_sel_e,
   output logic       muldiv_start_e,
   output logic [1:0] muldiv_op_e,
   output logic       data_memory_write_enable_m,
   output logic       reg_write_enable_m,
   output logic [1:0] reg_write_data_sel_m,
   output logic [1:0] reg_write_data_sel_w,
   output logic       reg_write_enable_w,
   output logic       hi_lo_busy,
   output logic       hi_lo_write_enable
);

   ctrl_bundle_t ctrl_d, ctrl_e;
   mem_ctrl_t    ctrl_m;
   wb_ctrl_t     ctrl_w;

   assign ctrl_d = decode(opcode_d, funct_d);

   // A start already in E counts as busy: the counter only loads at the next edge.
   assign stall_fd = uses_hi_lo(opcode_d, funct_d) && (hi_lo_busy || ctrl_e.muldiv_start);

   // NOTE: default assigned first so no path through the case leaves pc_sel_d latched.
   always_comb begin
      pc_sel_d = PC_PLUS4;
      if (!stall_fd) begin
         case (opcode_d)
            OP_BEQ:  if (equal_d)  pc_sel_d = PC_BRANCH;
            OP_BNE:  if (!equal_d) pc_sel_d = PC_BRANCH;
            OP_J:    pc_sel_d = PC_JUMP;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_e <= BUBBLE;
         ctrl_m <= '{reg_write: 1'b0, mem_write: 1'b0, data_sel: SEL_ALU};
         ctrl_w <= '{reg_write: 1'b0, data_sel: SEL_ALU};
      end else begin
         ctrl_e <= (flush_e || stall_fd) ? BUBBLE : ctrl_d;
         ctrl_m <= '{reg_write: ctrl_e.reg_write, mem_write: ctrl_e.mem_write,
                     data_sel: ctrl_e.data_sel};
         ctrl_w <= '{reg_write: ctrl_m.reg_write, data_sel: ctrl_m.data_sel};
      end
   end

   muldiv_busy_tracker #(
      .MUL_LATENCY(MUL_LATENCY),
      .DIV_LATENCY(DIV_LATENCY)
   ) u_tracker (
      .clock             (clock),
      .reset_n           (reset_n),
      .start             (ctrl_e.muldiv_start),
      .op                (ctrl_e.muldiv_op),
      .hi_lo_busy        (hi_lo_busy),
      .hi_lo_write_enable(hi_lo_write_enable)
   );

   assign alu_control_e              = ctrl_e.alu_control;
   assign alu_src_b_sel_e            = ctrl_e.alu_src_b_sel;
   assign write_addr3_sel_e          = ctrl_e.write_addr3_sel;
   assign muldiv_start_e             = ctrl_e.muldiv_start;
   assign muldiv_op_e                = ctrl_e.muldiv_op;
   assign data_memory_write_enable_m = ctrl_m.mem_write;
   assign reg_write_enable_m         = ctrl_m.reg_write;
   assign reg_write_data_sel_m       = ctrl_m.data_sel;
   assign reg_write_enable_w         = ctrl_w.reg_write;
   assign reg_write_data_sel_w       = ctrl_w.data_sel;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: stimulus queues expected W-stage
// writes, muldiv starts and HI/LO commit cycles; a negedge monitor pops them.
module tb_pipe_control_unit;
   import mips_ctrl_pkg::*;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [5:0] opcode_d, funct_d;
   logic       equal_d, flush_e;
   logic [1:0] pc_sel_d;
   logic       stall_fd;
   logic [5:0] alu_control_e;
   logic       alu_src_b_sel_e, write_addr3_sel_e, muldiv_start_e;
   logic [1:0] muldiv_op_e;
   logic       data_memory_write_enable_m, reg_write_enable_m;
   logic [1:0] reg_write_data_sel_m, reg_write_data_sel_w;
   logic       reg_write_enable_w, hi_lo_busy, hi_lo_write_enable;

   localparam logic [5:0] OP_UNDEF = 6'b111111;

   pipe_control_unit #(.MUL_LATENCY(4), .DIV_LATENCY(32)) dut (
      .clock                     (clock),
      .reset_n                   (reset_n),
      .opcode_d                  (opcode_d),
      .funct_d                   (funct_d),
      .equal_d                   (equal_d),
      .flush_e                   (flush_e),
      .pc_sel_d                  (pc_sel_d),
      .stall_fd                  (stall_fd),
      .alu_control_e             (alu_control_e),
      .alu_src_b_sel_e           (alu_src_b_sel_e),
      .write_addr3_sel_e         (write_addr3_sel_e),
      .muldiv_start_e            (muldiv_start_e),
      .muldiv_op_e               (muldiv_op_e),
      .data_memory_write_enable_m(data_memory_write_enable_m),
      .reg_write_enable_m        (reg_write_enable_m),
      .reg_write_data_sel_m      (reg_write_data_sel_m),
      .reg_write_data_sel_w      (reg_write_data_sel_w),
      .reg_write_enable_w        (reg_write_enable_w),
      .hi_lo_busy                (hi_lo_busy),
      .hi_lo_write_enable        (hi_lo_write_enable)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   logic [1:0] wq[$];
   logic [1:0] mq[$];
   int         pq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_d(input logic [5:0] op, input logic [5:0] fn, input logic eq);
      opcode_d = op;
      funct_d  = fn;
      equal_d  = eq;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Monitor: every observed event must match the head of its queue.
   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         if (reg_write_enable_w) begin
            check("w_write_expected", {31'b0, wq.size() != 0}, 32'd1);
            if (wq.size() != 0) check("data_sel_w", {30'b0, reg_write_data_sel_w}, {30'b0, wq.pop_front()});
         end
         if (muldiv_start_e) begin
            check("start_expected", {31'b0, mq.size() != 0}, 32'd1);
            if (mq.size() != 0) check("muldiv_op_e", {30'b0, muldiv_op_e}, {30'b0, mq.pop_front()});
         end
         if (hi_lo_write_enable) begin
            check("hilo_pulse_expected", {31'b0, pq.size() != 0}, 32'd1);
            if (pq.size() != 0) check("hilo_pulse_cycle", cyc, pq.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset_n = 1'b0;
      flush_e = 1'b0;
      set_d(OP_RTYPE, F_ADD, 1'b0);
      tick();
      tick();
      // Reset state with ADD on D
      check("rst_alu_control_e", alu_control_e, ALU_NOOP);
      check("rst_muldiv_start_e", muldiv_start_e, 0);
      check("rst_reg_write_m", reg_write_enable_m, 0);
      check("rst_mem_write_m", data_memory_write_enable_m, 0);
      check("rst_reg_write_w", reg_write_enable_w, 0);
      check("rst_data_sel_w", reg_write_data_sel_w, 0);
      check("rst_hi_lo_busy", hi_lo_busy, 0);
      check("rst_hi_lo_we", hi_lo_write_enable, 0);
      check("rst_stall_fd", stall_fd, 0);
      check("rst_pc_sel_d", pc_sel_d, 0);
      reset_n = 1'b1;
      wq.push_back(2'd0);
      tick();
      set_d(OP_UNDEF, 6'd0, 1'b0);
      #1;
      check("add_alu_control_e", alu_control_e, 6'b100000);
      check("add_write_addr3_sel_e", write_addr3_sel_e, 0);
      check("add_alu_src_b_sel_e", alu_src_b_sel_e, 0);
      tick();
      check("add_reg_write_m", reg_write_enable_m, 1);
      tick();
      check("add_reg_write_w", reg_write_enable_w, 1);
      tick();

      // MULT then dependent MFHI
      set_d(OP_RTYPE, F_MULT, 1'b0);
      mq.push_back(2'd0);
      pq.push_back(cyc + 5);
      #1;
      check("mult_no_stall", stall_fd, 0);
      tick();
      set_d(OP_RTYPE, F_MFHI, 1'b0);
      #1;
      n = 0;
      for (int g = 0; g < 40 && stall_fd; g++) begin
         n++;
         tick();
      end
      check("mult_stall_cycles", n, 5);
      wq.push_back(2'd2);
      tick();
      set_d(OP_UNDEF, 6'd0, 1'b0);
      #1;
      check("mfhi_e_alu_noop", alu_control_e, ALU_NOOP);
      check("mfhi_e_busy_clear", hi_lo_busy, 0);
      tick();
      tick();
      tick();

      // DIVU then independent ADD
      set_d(OP_RTYPE, F_DIVU, 1'b0);
      mq.push_back(2'd3);
      pq.push_back(cyc + 33);
      #1;
      tick();
      set_d(OP_RTYPE, F_ADD, 1'b0);
      wq.push_back(2'd0);
      #1;
      check("divu_add_no_stall", stall_fd, 0);
      tick();
      set_d(OP_UNDEF, 6'd0, 1'b0);
      #1;
      n = 0;
      for (int g = 0; g < 100 && hi_lo_busy; g++) begin
         n++;
         tick();
      end
      check("divu_busy_cycles", n, 32);

      // Branch / jump / undefined
      set_d(OP_BEQ, 6'd0, 1'b1); #1;
      check("beq_taken", pc_sel_d, 1);
      set_d(OP_BNE, 6'd0, 1'b1); #1;
      check("bne_equal", pc_sel_d, 0);
      set_d(OP_BNE, 6'd0, 1'b0); #1;
      check("bne_not_equal", pc_sel_d, 1);
      set_d(OP_J, 6'd0, 1'b0); #1;
      check("j_pc_sel", pc_sel_d, 2);
      set_d(OP_UNDEF, 6'd0, 1'b0); #1;
      check("undef_pc_sel", pc_sel_d, 0);
      tick();
      check("undef_bubble_alu", alu_control_e, ALU_NOOP);
      check("undef_bubble_start", muldiv_start_e, 0);
      set_d(OP_RTYPE, 6'b111111, 1'b0);
      tick();
      check("undef_funct_bubble", alu_control_e, ALU_NOOP);
      set_d(OP_UNDEF, 6'd0, 1'b0);
      tick();
      tick();

      // flush_e with LW in D, then LW again
      set_d(OP_LW, 6'd0, 1'b0);
      flush_e = 1'b1;
      tick();
      flush_e = 1'b0;
      wq.push_back(2'd1);
      #1;
      check("flush_e_bubble_alu", alu_control_e, ALU_NOOP);
      check("flush_e_bubble_srcb", alu_src_b_sel_e, 0);
      tick();
      set_d(OP_UNDEF, 6'd0, 1'b0);
      #1;
      check("flush_m_bubble", reg_write_enable_m, 0);
      check("lw_e_srcb", alu_src_b_sel_e, 1);
      check("lw_e_wa3", write_addr3_sel_e, 1);
      check("lw_e_alu", alu_control_e, 6'b100000);
      tick();
      check("lw_m_reg_write", reg_write_enable_m, 1);
      check("lw_m_data_sel", reg_write_data_sel_m, 1);
      check("flush_w_bubble", reg_write_enable_w, 0);
      set_d(OP_SW, 6'd0, 1'b0);
      tick();
      set_d(OP_UNDEF, 6'd0, 1'b0);
      tick();
      check("sw_m_mem_write", data_memory_write_enable_m, 1);
      check("sw_m_no_reg_write", reg_write_enable_m, 0);
      tick();
      tick();

      // Reset during DIV busy cycle 2
      set_d(OP_RTYPE, F_DIV, 1'b0);
      mq.push_back(2'd2);
      tick();
      set_d(OP_RTYPE, F_MFHI, 1'b0);
      #1;
      check("div_start_stall", stall_fd, 1);
      tick();
      check("div_busy_1", hi_lo_busy, 1);
      tick();
      check("div_busy_2", hi_lo_busy, 1);
      reset_n = 1'b0;
      #1;
      check("abort_busy", hi_lo_busy, 0);
      check("abort_we", hi_lo_write_enable, 0);
      check("abort_stall", stall_fd, 0);
      tick();
      tick();
      set_d(OP_UNDEF, 6'd0, 1'b0);
      reset_n = 1'b1;
      repeat (40) tick();

      check("w_queue_drained", wq.size(), 0);
      check("start_queue_drained", mq.size(), 0);
      check("pulse_queue_drained", pq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
